// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory sequencer: held request, pipeline stall, load-data latch
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [15:0] iAddr,
    input  logic [15:0] iWData,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] MemRd,
    output logic        mem_stall,
    output logic        err_align,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       acc;
    logic       timeout_hit;
    logic [4:0] wait_cnt;

    assign acc         = iMemRead | iMemWrite;
    assign timeout_hit = (wait_cnt == 5'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = acc;
                if (acc) state_nxt = BUSY;
            end
            BUSY: begin
                mem_en    = 1'b1;
                mem_stall = 1'b1;
                if (mem_ack || timeout_hit) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Stall must drop the instant reset rises, even if EX/MEM still shows an access
        if (rst) mem_stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_wr      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 16'h0000;
            MemRd       <= 16'h0000;
            wait_cnt    <= 5'd0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    wait_cnt <= 5'd0;
                    if (acc) begin
                        // Write wins when both strobes are set
                        mem_wr    <= iMemWrite;
                        mem_addr  <= {iAddr[15:1], 1'b0};
                        mem_wdata <= iWData;
                        if (iAddr[0]) err_align <= 1'b1;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + 5'd1;
                    if (mem_ack) begin
                        if (!mem_wr) MemRd <= mem_rdata;
                    end else if (timeout_hit) begin
                        if (!mem_wr) MemRd <= 16'hFFFF;
                        err_timeout <= 1'b1;
                    end
                end
                DONE: wait_cnt <= 5'd0;
                default: wait_cnt <= 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        iMemRead, iMemWrite;
    logic [15:0] iAddr, iWData;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] MemRd;
    logic        mem_stall, err_align, err_timeout;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .iAddr      (iAddr),
        .iWData     (iWData),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .MemRd      (MemRd),
        .mem_stall  (mem_stall),
        .err_align  (err_align),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] memrd;
        int          stall;
        logic        align;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_memrd = 16'h0000;
    logic        m_align = 1'b0;
    logic        m_tmo   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one tick after a rising edge with the DUT in IDLE; returns in the following IDLE
    task automatic run_access(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input int ack_lat, input logic [15:0] rdata);
        exp_t e;
        int   stall;
        bit   done;
        bit   acked;
        iMemRead  = rd;
        iMemWrite = wr;
        iAddr     = addr;
        iWData    = wdata;
        acked = (ack_lat >= 1) && (ack_lat <= TIMEOUT);
        if (!wr) m_memrd = acked ? rdata : 16'hFFFF;
        if (addr[0]) m_align = 1'b1;
        if (!acked) m_tmo = 1'b1;
        e.memrd = m_memrd;
        e.stall = acked ? ack_lat + 1 : TIMEOUT + 1;
        e.align = m_align;
        e.tmo   = m_tmo;
        sb.push_back(e);
        #1;
        chk("idle_stall", 32'(mem_stall), 32'd1);
        chk("idle_en", 32'(mem_en), 32'd0);
        stall = 1;
        done  = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            #1;
            if (!mem_stall) begin
                done = 1;
            end else begin
                stall++;
                chk("busy_en", 32'(mem_en), 32'd1);
                chk("busy_wr", 32'(mem_wr), 32'(wr));
                chk("busy_addr", 32'(mem_addr), 32'({addr[15:1], 1'b0}));
                if (wr) chk("busy_wdata", 32'(mem_wdata), 32'(wdata));
                iAddr     = 16'($urandom_range(0, 65535));
                iWData    = 16'($urandom_range(0, 65535));
                mem_ack   = (k == ack_lat);
                mem_rdata = (k == ack_lat) ? rdata : 16'($urandom_range(0, 65535));
            end
        end
        if (!done) chk("done_reached", 32'd0, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("done_memrd", 32'(MemRd), 32'(e.memrd));
            chk("stall_cycles", 32'(stall), 32'(e.stall));
            chk("done_en", 32'(mem_en), 32'd0);
            chk("err_align", 32'(err_align), 32'(e.align));
            chk("err_timeout", 32'(err_timeout), 32'(e.tmo));
        end
        step();
        iMemRead  = 1'b0;
        iMemWrite = 1'b0;
        #1;
        chk("post_idle_en", 32'(mem_en), 32'd0);
        chk("post_idle_stall", 32'(mem_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        iMemRead = 1'b0; iMemWrite = 1'b0; iAddr = 16'h0; iWData = 16'h0;
        mem_rdata = 16'h0; mem_ack = 1'b0;
        step();
        step();
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_memrd", 32'(MemRd), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_flags", 32'({err_align, err_timeout}), 32'd0);
        rst = 1'b0;
        step();

        run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 4, 16'hBEEF);
        run_access(1'b0, 1'b1, 16'h0020, 16'h1234, 1, 16'h0000);
        run_access(1'b1, 1'b0, 16'h0030, 16'h0000, 2, 16'hAAAA);
        run_access(1'b1, 1'b0, 16'h0032, 16'h0000, 3, 16'h5555);
        run_access(1'b1, 1'b0, 16'h0100, 16'h0000, TIMEOUT, 16'h0F0F);
        run_access(1'b1, 1'b0, 16'h0013, 16'h0000, 1, 16'h7777);
        run_access(1'b1, 1'b1, 16'h0044, 16'hC0DE, 2, 16'h9999);
        run_access(1'b1, 1'b0, 16'h0050, 16'h0000, 0, 16'h0000);
        step();
        chk("sticky_align", 32'(err_align), 32'd1);
        chk("sticky_tmo", 32'(err_timeout), 32'd1);

        iMemRead = 1'b1;
        iAddr    = 16'h0040;
        step();
        step();
        step();
        chk("pre_rst_busy", 32'(mem_en), 32'd1);
        rst      = 1'b1;
        iMemRead = 1'b0;
        #1;
        chk("arst_en", 32'(mem_en), 32'd0);
        chk("arst_stall", 32'(mem_stall), 32'd0);
        chk("arst_memrd", 32'(MemRd), 32'd0);
        chk("arst_flags", 32'({err_align, err_timeout}), 32'd0);
        step();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        #1;
        chk("stray_ack_memrd", 32'(MemRd), 32'd0);
        chk("stray_ack_en", 32'(mem_en), 32'd0);
        m_memrd = 16'h0000;
        m_align = 1'b0;
        m_tmo   = 1'b0;
        step();
        run_access(1'b1, 1'b0, 16'h0060, 16'h0000, 2, 16'h4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
